seq_shifter: RTL and testbench

Parametrised multi-cycle shifter that shifts a WIDTH-bit operand by a programmable amount, one bit position per clock, in one of four modes (logical left, logical right, arithmetic right, rotate right). It sits beside the datapath ALU as its shift unit. A controller FSM issues a start pulse, waits for done, and then reads the result and the carry-out bit. It replaces the fixed single-bit shift stage with a variable-amount, handshaked unit.

---
 rtl/shifter_pkg.sv | 18 +
 rtl/shift_step.sv | 46 ++++
 rtl/seq_shifter.sv | 109 ++++++++++
 tb/tb_seq_shifter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg
// Shared definitions for the multi-cycle shift unit.
//   MODE_*  : 2-bit shift mode codes carried on the mode input
//   state_t : controller state encoding (IDLE / SHIFT / DONE)
package shifter_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step
// Purely combinational single-bit shift step.
//   r_i    : current operand value
//   mode_i : shift mode (MODE_LSL / MODE_LSR / MODE_ASR / MODE_ROR)
//   r_o    : operand after one bit-position shift
//   out_o  : bit that leaves the operand during this step
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] r_o,
  output logic             out_o
);

  always_comb begin
    r_o   = r_i;
    out_o = 1'b0;
    case (mode_i)
      MODE_LSL: begin
        r_o   = {r_i[WIDTH-2:0], 1'b0};
        out_o = r_i[WIDTH-1];
      end
      MODE_LSR: begin
        r_o   = {1'b0, r_i[WIDTH-1:1]};
        out_o = r_i[0];
      end
      MODE_ASR: begin
        // Sign bit is replicated into the vacated MSB.
        r_o   = {r_i[WIDTH-1], r_i[WIDTH-1:1]};
        out_o = r_i[0];
      end
      MODE_ROR: begin
        r_o   = {r_i[0], r_i[WIDTH-1:1]};
        out_o = r_i[0];
      end
      default: begin
        r_o   = r_i;
        out_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter
// Multi-cycle variable-amount shifter, one bit position per clock.
// A start pulse in IDLE or DONE latches the operand, mode and amount;
// the unit then shifts for 'amount' cycles plus one cycle to detect
// completion, and pulses done for one cycle with the result on sout.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears all state
//   start  : request pulse, sampled only in IDLE or DONE
//   in     : operand, latched on an accepted start
//   mode   : 00 LSL, 01 LSR, 10 ASR, 11 ROR, latched with in
//   amount : shift count 0..WIDTH-1, latched with in
//   busy   : high while shifting
//   done   : one-cycle completion pulse
//   sout   : result, valid from done until the next accepted start
//   carry  : last bit shifted out (0 for a zero-amount shift)
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         in,
  input  logic [1:0]               mode,
  input  logic [$clog2(WIDTH)-1:0] amount,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         sout,
  output logic                     carry
);

  localparam int AMT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               carry_q, carry_d;

  logic [WIDTH-1:0]   step_r;
  logic               step_out;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i    (r_q),
    .mode_i (mode_q),
    .r_o    (step_r),
    .out_o  (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_LSL;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new start directly so back-to-back operations
        // need no idle cycle in between.
        if (start) begin
          r_d     = in;
          cnt_d   = amount;
          mode_d  = mode;
          carry_d = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // start is deliberately not looked at here.
        if (cnt_q != '0) begin
          r_d     = step_r;
          cnt_d   = cnt_q - AMT_W'(1);
          carry_d = step_out;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registers; no input reaches them combinationally.
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign sout  = r_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] in_v;
  logic [1:0]   mode;
  logic [3:0]   amount;
  logic         busy;
  logic         done;
  logic [W-1:0] sout;
  logic         carry;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in     (in_v),
    .mode   (mode),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .sout   (sout),
    .carry  (carry)
  );

  typedef struct {
    logic [15:0] x;
    logic [1:0]  m;
    logic [3:0]  a;
    bit          inject;
    bit          b2b;
    logic [15:0] exp_sout;
    logic        exp_carry;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  // Whole-operation reference: result of shifting by 'a' at once.
  function automatic void model(input logic [15:0] x, input logic [1:0] m, input int a,
                                output logic [15:0] r, output logic c);
    int unsigned v;
    int          sx;
    v  = 32'(x);
    sx = 32'($signed(x));
    c  = 1'b0;
    case (m)
      2'd0: begin r = 16'(v << a); if (a > 0) c = x[16-a]; end
      2'd1: begin r = 16'(v >> a); if (a > 0) c = x[a-1]; end
      2'd2: begin r = 16'(sx >>> a); if (a > 0) c = x[a-1]; end
      default: begin r = 16'((v >> a) | (v << (16 - a))); if (a > 0) c = x[a-1]; end
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [15:0] x, input logic [1:0] m,
                       input logic [3:0] a, input bit inject, input bit b2b,
                       input logic [15:0] es, input logic ec);
    int n;
    int bcnt;
    bit ovl;
    bit got;
    @(negedge clk);
    if (b2b) chk({tag, " done at issue"}, 32'(done), 32'd1);
    start  = 1'b1;
    in_v   = x;
    mode   = m;
    amount = a;
    @(posedge clk);
    #1;
    bcnt = busy ? 1 : 0;
    ovl  = busy && done;
    n    = 0;
    got  = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      start = inject && (n < 2);
      if (start) begin
        in_v   = ~x;
        mode   = ~m;
        amount = a + 4'd3;
      end
      @(posedge clk);
      n++;
      #1;
      if (busy) bcnt++;
      if (busy && done) ovl = 1'b1;
      if (done) got = 1'b1;
    end
    chk({tag, " done seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(int'(a) + 1));
    chk({tag, " busy cycles"}, 32'(bcnt), 32'(int'(a) + 1));
    chk({tag, " busy&done"}, 32'(ovl), 32'd0);
    chk({tag, " sout"}, 32'(sout), 32'(es));
    chk({tag, " carry"}, 32'(carry), 32'(ec));
  endtask

  initial begin
    vec_t        tbl[8];
    logic [15:0] er;
    logic        ec;
    bit          seen;

    tbl[0] = '{16'h8001, 2'd0, 4'd1,  1'b0, 1'b0, 16'h0002, 1'b1};
    tbl[1] = '{16'h8000, 2'd2, 4'd3,  1'b0, 1'b0, 16'hF000, 1'b0};
    tbl[2] = '{16'h8000, 2'd1, 4'd3,  1'b0, 1'b0, 16'h1000, 1'b0};
    tbl[3] = '{16'h0008, 2'd3, 4'd4,  1'b0, 1'b0, 16'h8000, 1'b1};
    tbl[4] = '{16'hFFFF, 2'd1, 4'd15, 1'b0, 1'b0, 16'h0001, 1'b1};
    tbl[5] = '{16'h1234, 2'd2, 4'd0,  1'b0, 1'b0, 16'h1234, 1'b0};
    tbl[6] = '{16'h00F0, 2'd0, 4'd8,  1'b1, 1'b0, 16'hF000, 1'b0};
    tbl[7] = '{16'h00F0, 2'd3, 4'd5,  1'b0, 1'b1, 16'h8007, 1'b1};

    reset  = 1'b1;
    start  = 1'b0;
    in_v   = '0;
    mode   = 2'd0;
    amount = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sout", 32'(sout), 32'd0);
    chk("reset carry", 32'(carry), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (!tbl[i].b2b) repeat (2) @(posedge clk);
      do_op($sformatf("vec%0d", i), tbl[i].x, tbl[i].m, tbl[i].a, tbl[i].inject,
            tbl[i].b2b, tbl[i].exp_sout, tbl[i].exp_carry);
    end

    // Asynchronous reset in the middle of a shift.
    repeat (2) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    in_v   = 16'hABCD;
    mode   = 2'd1;
    amount = 4'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midshift busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset sout", 32'(sout), 32'd0);
    chk("async reset carry", 32'(carry), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("no activity after reset", 32'(seen), 32'd0);
    do_op("after reset", 16'h00C3, 2'd3, 4'd2, 1'b0, 1'b0, 16'hC030, 1'b1);

    // Random operations against the whole-shift reference model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x;
      logic [1:0]  m;
      logic [3:0]  a;
      bit          b2b;
      x   = 16'($urandom);
      m   = 2'($urandom_range(0, 3));
      a   = 4'($urandom_range(0, 15));
      b2b = 1'($urandom_range(0, 1));
      model(x, m, int'(a), er, ec);
      if (!b2b) repeat (2) @(posedge clk);
      do_op($sformatf("rand%0d m%0d a%0d", i, m, a), x, m, a, 1'b0, b2b, er, ec);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
